// File: rtl/param_rr_arbiter_if.sv
// Requester/sink bundle for param_rr_arbiter.
// Signal directions are named from the arbiter's point of view.
interface param_rr_arbiter_if #(
   parameter int unsigned NumReq    = 5,
   parameter int unsigned DataWidth = 8
);
   localparam int unsigned IdxWidth = (NumReq > 1) ? unsigned'($clog2(NumReq)) : 1;

   logic [NumReq-1:0]                req_i;
   logic [NumReq-1:0][DataWidth-1:0] data_i;
   logic [NumReq-1:0]                gnt_o;
   logic                             valid_o;
   logic                             ready_i;
   logic [DataWidth-1:0]             data_o;
   logic [IdxWidth-1:0]              idx_o;

   modport master (
      input  req_i,
      input  data_i,
      input  ready_i,
      output gnt_o,
      output valid_o,
      output data_o,
      output idx_o
   );

   modport slave (
      output req_i,
      output data_i,
      output ready_i,
      input  gnt_o,
      input  valid_o,
      input  data_o,
      input  idx_o
   );
endinterface

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter for NumReq requesters feeding one valid/ready sink
// through a single-entry registered output stage.
module param_rr_arbiter #(
   parameter int unsigned NumReq    = 5,
   parameter int unsigned DataWidth = 8
) (
   input logic                clk_i,
   input logic                rst_i,
   param_rr_arbiter_if.master bus
);
   localparam int unsigned IdxWidth = (NumReq > 1) ? unsigned'($clog2(NumReq)) : 1;

   if (NumReq < 1) begin : gen_bad_num_req
      $error("param_rr_arbiter: NumReq must be >= 1");
   end

   typedef enum logic {StEmpty, StFull} state_e;

   state_e               state_q, state_d;
   logic [IdxWidth-1:0]  rr_q, rr_d;
   logic [IdxWidth-1:0]  idx_q;
   logic [DataWidth-1:0] data_q;
   logic [IdxWidth-1:0]  win_idx;
   logic [IdxWidth:0]    cand;
   logic                 win_found;
   logic                 accept;
   logic                 grant;
   logic [NumReq-1:0]    gnt;

   assign accept = (state_q == StEmpty) || bus.ready_i;
   assign grant  = accept && win_found && !rst_i;

   // Search rr_q..NumReq-1 then 0..rr_q-1; wrap at NumReq, not at 2**IdxWidth.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = {1'b0, rr_q} + (IdxWidth+1)'(i);
         if (cand >= (IdxWidth+1)'(NumReq)) begin
            cand = cand - (IdxWidth+1)'(NumReq);
         end
         if (!win_found && bus.req_i[cand[IdxWidth-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IdxWidth-1:0];
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (grant) begin
         gnt[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      if (grant) begin
         rr_d = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
      end
      unique case (state_q)
         StEmpty: if (grant) state_d = StFull;
         StFull:  if (bus.ready_i) state_d = grant ? StFull : StEmpty;
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StEmpty;
         rr_q    <= '0;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         if (grant) begin
            data_q <= bus.data_i[win_idx];
            idx_q  <= win_idx;
         end
      end
   end

   assign bus.gnt_o   = gnt;
   assign bus.valid_o = (state_q == StFull);
   assign bus.data_o  = data_q;
   assign bus.idx_o   = idx_q;
endmodule

// File: tb/tb_param_rr_arbiter.sv
// Directed bench for param_rr_arbiter with NumReq=5, DataWidth=8.
module tb_param_rr_arbiter;
   localparam int unsigned NumReq    = 5;
   localparam int unsigned DataWidth = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   param_rr_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth)) bus ();

   param_rr_arbiter #(
      .NumReq    (NumReq),
      .DataWidth (DataWidth)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check grant before the edge, then the registered result after it.
   task automatic grant_cycle(input string tag, input int k);
      #1;
      check_eq({tag, " gnt"}, 32'(bus.gnt_o), 32'(1) << k);
      tick();
      check_eq({tag, " valid"}, 32'(bus.valid_o), 32'd1);
      check_eq({tag, " idx"}, 32'(bus.idx_o), 32'(k));
      check_eq({tag, " data"}, 32'(bus.data_o), 32'h10 + 32'(k));
   endtask

   int fair_seq[7] = '{0, 1, 2, 3, 4, 0, 1};

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.req_i   = 5'b11111;
      bus.ready_i = 1'b1;
      for (int k = 0; k < int'(NumReq); k++) bus.data_i[k] = 8'(8'h10 + k);

      // Reset with all requests high
      #2;
      check_eq("rst gnt", 32'(bus.gnt_o), 32'd0);
      check_eq("rst valid", 32'(bus.valid_o), 32'd0);
      check_eq("rst idx", 32'(bus.idx_o), 32'd0);
      check_eq("rst data", 32'(bus.data_o), 32'd0);
      tick();
      check_eq("rst gnt held", 32'(bus.gnt_o), 32'd0);
      check_eq("rst valid held", 32'(bus.valid_o), 32'd0);
      rst = 1'b0;

      // Fairness and wrap at NumReq
      for (int i = 0; i < 7; i++) grant_cycle($sformatf("fair%0d", i), fair_seq[i]);

      // Backpressure with idx_o=2
      grant_cycle("pre_bp", 2);
      bus.ready_i = 1'b0;
      bus.req_i   = 5'b11011;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("bp%0d gnt", i), 32'(bus.gnt_o), 32'd0);
         tick();
         check_eq($sformatf("bp%0d valid", i), 32'(bus.valid_o), 32'd1);
         check_eq($sformatf("bp%0d idx", i), 32'(bus.idx_o), 32'd2);
         check_eq($sformatf("bp%0d data", i), 32'(bus.data_o), 32'h12);
      end
      bus.ready_i = 1'b1;
      grant_cycle("bp_release", 3);

      // Sparse requests from rr_q=1
      bus.req_i = 5'b00001;
      grant_cycle("sp_setup", 0);
      bus.req_i = 5'b10001;
      grant_cycle("sp0", 4);
      grant_cycle("sp1", 0);
      grant_cycle("sp2", 4);
      grant_cycle("sp3", 0);

      // Drain a single payload from index 3
      bus.req_i = 5'b01000;
      grant_cycle("drain_push", 3);
      bus.req_i = 5'b00000;
      #1;
      check_eq("drain gnt", 32'(bus.gnt_o), 32'd0);
      tick();
      check_eq("drain valid", 32'(bus.valid_o), 32'd0);
      check_eq("drain idx hold", 32'(bus.idx_o), 32'd3);
      check_eq("drain data hold", 32'(bus.data_o), 32'h13);
      tick();
      check_eq("drain valid stays", 32'(bus.valid_o), 32'd0);

      // Mid-operation async reset while FULL and stalled
      bus.req_i = 5'b00001;
      grant_cycle("mid_push", 0);
      bus.ready_i = 1'b0;
      bus.req_i   = 5'b01000;
      tick();
      check_eq("mid stall valid", 32'(bus.valid_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid rst valid", 32'(bus.valid_o), 32'd0);
      check_eq("mid rst data", 32'(bus.data_o), 32'd0);
      check_eq("mid rst idx", 32'(bus.idx_o), 32'd0);
      check_eq("mid rst gnt", 32'(bus.gnt_o), 32'd0);
      #1;
      rst = 1'b0;
      grant_cycle("mid_after", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/param_rr_arbiter.md
# param_rr_arbiter

Round-robin arbiter with a single-entry registered output stage. It shares one downstream valid/ready sink between `NumReq` requesters. Index and pointer widths are derived from `NumReq`, so non-power-of-two requester counts must wrap correctly inside a `2**IdxWidth` index space. It sits in front of a shared datapath resource and serialises access to it with fair, starvation-free grants.

## Interface
- `NumReq`, default 5: number of requesters; must be >= 1 (elaboration error otherwise).
- `DataWidth`, default 8: payload width per requester.
- `IdxWidth`, derived localparam: `unsigned'($clog2(NumReq))` if `NumReq > 1`, else 1.
- `IdxSpace`, derived localparam: `2**IdxWidth`; index codes in `[NumReq, IdxSpace-1]` are illegal and never emitted.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  NumReq  per-requester request (valid).
- `data_i`  in  NumReq x DataWidth  per-requester payload; sampled when the matching `gnt_o` bit is high.
- `gnt_o`  out  NumReq  per-requester grant; at most one bit high (one-hot or zero).
- `valid_o`  out  1  output stage holds a payload.
- `ready_i`  in  1  sink accepts the payload.
- `data_o`  out  DataWidth  registered payload.
- `idx_o`  out  IdxWidth  index of the requester that supplied `data_o`.

## Operation
- The output stage has two states:
  - EMPTY (`valid_o=0`).
  - FULL (`valid_o=1`).
- `accept = !valid_o || ready_i`. Arbitration happens only when `accept=1`.
- Winner selection:
  - Search upward from the pointer `rr_q`: `rr_q..NumReq-1`, then `0..rr_q-1`.
  - The first index `k` with `req_i[k]=1` wins.
  - `gnt_o[k] = accept && req_i[k]`. All other grant bits are 0.
  - `gnt_o` is combinational from `req_i`, `rr_q`, `valid_o` and `ready_i`.
- On grant to `k`:
  - `data_o <= data_i[k]`, `idx_o <= k`, state becomes FULL.
  - `rr_q <= (k == NumReq-1) ? 0 : k+1`.
  - The pointer wraps at `NumReq`, never at `IdxSpace`.
- FULL with `ready_i=1` and no request: state becomes EMPTY. `data_o` and `idx_o` hold their last value.
- FULL with `ready_i=0`:
  - Hold. `data_o`, `idx_o` and `valid_o` stay stable.
  - `gnt_o` is all-zero.
  - `rr_q` is unchanged.
- FULL with `ready_i=1` and a request present: pop and push in the same cycle. State stays FULL with the new payload (no bubble).
- No grant means `rr_q` is unchanged.
- Requesters may drop `req_i` without a grant. The arbiter keeps no per-requester state.
- `rr_q` is `IdxWidth` bits wide and always holds a value `< NumReq`.
- `NumReq=1`: `rr_q` stays 0; the block degenerates to a registered pass-through.

## Timing
- Reset values (asynchronous, immediate on `rst_i` assertion):
  - `valid_o=0`, `data_o=0`, `idx_o=0`, `rr_q=0`.
  - `gnt_o=0` while `rst_i` is high, regardless of `req_i`.
- Latency: grant in cycle N gives `valid_o=1` with that payload in cycle N+1.
- Throughput: one payload per cycle while `ready_i=1` and requests are present.
- `valid_o`, `data_o` and `idx_o` are driven only from registers. There is no combinational path from `req_i` or `data_i` to any of them.
- Combinational paths exist from `ready_i` and `req_i` to `gnt_o` only.
- Reset mid-transfer drops the held payload. The first cycle after release behaves as EMPTY with `rr_q=0`.

## Test plan
- Reset: assert `rst_i` with `req_i=5'b11111` -> `gnt_o=0`, `valid_o=0`, `idx_o=0`, `data_o=0`. After release, the first grant goes to index 0.
- Fairness and wrap (`NumReq=5`): hold `req_i=5'b11111`, `ready_i=1`, `data_i[k]=8'h10+k` -> `idx_o` sequence is 0,1,2,3,4,0,1 on consecutive cycles, `data_o` matches. `idx_o` never takes values 5..7.
- Backpressure: FULL with `idx_o=2`, hold `ready_i=0` for 4 cycles while `req_i=5'b11011` -> `gnt_o=0`, and `data_o`/`idx_o` stay stable. When `ready_i=1` returns, the next grant is 3.
- Sparse requests: `req_i=5'b10001`, `ready_i=1`, starting from `rr_q=1` -> grants alternate 4,0,4,0. `rr_q` goes 0 after 4 and 1 after 0.
- Drain: a single request to index 3, then `req_i=0` with `ready_i=1` -> `valid_o` is high for exactly one cycle, then EMPTY, and `idx_o` holds 3.
- Mid-operation reset: FULL with `ready_i=0`, pulse `rst_i` asynchronously between edges -> `valid_o` drops immediately. After release with `req_i=5'b01000`, the grant goes to 3 in the first cycle.
